vga_timing_gen: RTL

// - Source end of the pixel stream consumed by the overlay/draw stages: generates hcount/vcount, hsync/vsync,

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_axis_counter.sv | 58 +++++
 rtl/vga_timing_gen.sv | 79 +++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Default 800x600@60 (40 MHz) timing constants shared by the timing generator and the draw stages.
package vga_pkg;

    localparam int unsigned COUNT_W     = 12;
    localparam int unsigned FRAME_CNT_W = 16;
    localparam int unsigned MAX_COUNT   = (1 << COUNT_W) - 1;

    localparam int unsigned VGA_H_VISIBLE = 800;
    localparam int unsigned VGA_H_FPORCH  = 40;
    localparam int unsigned VGA_H_SYNC    = 128;
    localparam int unsigned VGA_H_BPORCH  = 88;
    localparam int unsigned VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FPORCH + VGA_H_SYNC + VGA_H_BPORCH;
    localparam int unsigned VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FPORCH;
    localparam int unsigned VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;

    localparam int unsigned VGA_V_VISIBLE = 600;
    localparam int unsigned VGA_V_FPORCH  = 1;
    localparam int unsigned VGA_V_SYNC    = 4;
    localparam int unsigned VGA_V_BPORCH  = 23;
    localparam int unsigned VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FPORCH + VGA_V_SYNC + VGA_V_BPORCH;
    localparam int unsigned VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FPORCH;
    localparam int unsigned VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

    localparam logic [11:0] RGB_BLACK = 12'h000;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter with registered sync window and blank flag.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned VISIBLE  = VGA_H_VISIBLE,
    parameter int unsigned FPORCH   = VGA_H_FPORCH,
    parameter int unsigned SYNC     = VGA_H_SYNC,
    parameter int unsigned BPORCH   = VGA_H_BPORCH,
    parameter bit          SYNC_POL = 1'b1
) (
    input  logic               pclk,
    input  logic               reset_n,
    input  logic               advance,
    output logic [COUNT_W-1:0] count_out,
    output logic               sync_out,
    output logic               blnk_out,
    output logic               wrap
);

    localparam int unsigned TOTAL = VISIBLE + FPORCH + SYNC + BPORCH;

    if (TOTAL > MAX_COUNT) begin : g_width_check
        $error("vga_axis_counter: TOTAL exceeds counter range");
    end

    localparam logic [COUNT_W-1:0] LAST        = COUNT_W'(TOTAL - 1);
    localparam logic [COUNT_W-1:0] BLANK_START = COUNT_W'(VISIBLE);
    localparam logic [COUNT_W-1:0] SYNC_START  = COUNT_W'(VISIBLE + FPORCH);
    localparam logic [COUNT_W-1:0] SYNC_END    = COUNT_W'(VISIBLE + FPORCH + SYNC);

    logic [COUNT_W-1:0] count_nxt;
    logic               sync_nxt;
    logic               blnk_nxt;

    // Flags are decoded from the next count so they land in the same cycle as the count itself.
    always_comb begin
        wrap      = advance && (count_out == LAST);
        count_nxt = count_out;
        if (advance) begin
            count_nxt = wrap ? '0 : count_out + COUNT_W'(1);
        end
        sync_nxt = ((count_nxt >= SYNC_START) && (count_nxt < SYNC_END)) ? SYNC_POL : ~SYNC_POL;
        blnk_nxt = (count_nxt >= BLANK_START);
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            count_out <= '0;
            sync_out  <= ~SYNC_POL;
            blnk_out  <= 1'b0;
        end else begin
            count_out <= count_nxt;
            sync_out  <= sync_nxt;
            blnk_out  <= blnk_nxt;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Head of the draw chain: 800x600@60 counts, syncs, blanks, black background, frame strobe and counter.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
    parameter int unsigned H_FPORCH  = VGA_H_FPORCH,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BPORCH  = VGA_H_BPORCH,
    parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
    parameter int unsigned V_FPORCH  = VGA_V_FPORCH,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BPORCH  = VGA_V_BPORCH,
    parameter bit          SYNC_POL  = 1'b1
) (
    input  logic                   pclk,
    input  logic                   reset_n,
    input  logic                   enable,
    output logic [COUNT_W-1:0]     hcount_out,
    output logic                   hsync_out,
    output logic                   hblnk_out,
    output logic [COUNT_W-1:0]     vcount_out,
    output logic                   vsync_out,
    output logic                   vblnk_out,
    output logic [11:0]            rgb_out,
    output logic                   frame_start,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    logic h_wrap;
    logic v_wrap;

    vga_axis_counter #(
        .VISIBLE  (H_VISIBLE),
        .FPORCH   (H_FPORCH),
        .SYNC     (H_SYNC),
        .BPORCH   (H_BPORCH),
        .SYNC_POL (SYNC_POL)
    ) u_h_axis (
        .pclk      (pclk),
        .reset_n   (reset_n),
        .advance   (enable),
        .count_out (hcount_out),
        .sync_out  (hsync_out),
        .blnk_out  (hblnk_out),
        .wrap      (h_wrap)
    );

    // h_wrap already carries enable, so a stalled line never advances the frame.
    vga_axis_counter #(
        .VISIBLE  (V_VISIBLE),
        .FPORCH   (V_FPORCH),
        .SYNC     (V_SYNC),
        .BPORCH   (V_BPORCH),
        .SYNC_POL (SYNC_POL)
    ) u_v_axis (
        .pclk      (pclk),
        .reset_n   (reset_n),
        .advance   (h_wrap),
        .count_out (vcount_out),
        .sync_out  (vsync_out),
        .blnk_out  (vblnk_out),
        .wrap      (v_wrap)
    );

    assign rgb_out = RGB_BLACK;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            frame_start <= v_wrap;
            if (v_wrap) begin
                frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            end
        end
    end

endmodule
